// File: rtl/mem_read_seq.sv
// rtl/mem_read_seq.sv - two-requester memory read sequencer with 4-phase ack handoff; optional ack timeout via MEM_RD_TIMEOUT_EN
module mem_read_seq #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_instr,
  input  logic [7:0]  addr_instr,
  input  logic        req_cache,
  input  logic [7:0]  addr_cache,
  output logic        gnt_instr,
  output logic        gnt_cache,
  output logic        mem_en,
  output logic [7:0]  mem_addr,
  input  logic [13:0] mem_rdata,
  output logic [15:0] data_out,
  output logic [1:0]  PH0,
  input  logic        ack_instr,
  input  logic        ack_cache,
  output logic        err_timeout
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PRESENT, SPACER} state_e;

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);
  localparam logic [1:0] PH_INSTR = 2'b10;
  localparam logic [1:0] PH_CACHE = 2'b00;
  localparam logic [1:0] PH_NONE  = 2'b01;

  state_e      state_q;
  logic        gnt_instr_q, gnt_cache_q, mem_en_q;
  logic [7:0]  mem_addr_q;
  logic [15:0] data_q;
  logic [1:0]  ph0_q;
  logic        sel_instr_q;   // granted side of the transfer in flight
  logic        last_instr_q;  // side granted most recently (0 = cache)
  logic [3:0]  cnt_q;
  logic        ai_s1_q, ai_s2_q, ac_s1_q, ac_s2_q;
  logic        ack_s;
  logic        win_instr_d;
  logic        tmo_hit;

  // Two-flop synchronizers for the asynchronous acks from both sides
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ai_s1_q <= 1'b0;
      ai_s2_q <= 1'b0;
      ac_s1_q <= 1'b0;
      ac_s2_q <= 1'b0;
    end else begin
      ai_s1_q <= ack_instr;
      ai_s2_q <= ai_s1_q;
      ac_s1_q <= ack_cache;
      ac_s2_q <= ac_s1_q;
    end
  end

  // Only the granted side's ack is allowed to move the handshake
  assign ack_s = sel_instr_q ? ai_s2_q : ac_s2_q;

  // Round-robin between two: a lone request wins, contention goes to the side not granted last
  assign win_instr_d = req_instr & (~req_cache | ~last_instr_q);

`ifdef MEM_RD_TIMEOUT_EN
  logic [7:0] tmo_q;
  logic       err_q;
  logic       waiting;

  assign waiting     = ((state_q == PRESENT) && !ack_s) || ((state_q == SPACER) && ack_s);
  assign tmo_hit     = waiting && (tmo_q == 8'd254);
  assign err_timeout = err_q;

  // Count cycles spent waiting for the awaited ack edge; the error flag stays set until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= (waiting && !tmo_hit) ? tmo_q + 8'd1 : 8'd0;
      if (tmo_hit) err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Sequencer: arbitrate, issue one read strobe, wait out the memory latency, present, then spacer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_instr_q  <= 1'b0;
      gnt_cache_q  <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= 8'h00;
      data_q       <= 16'h0000;
      ph0_q        <= PH_NONE;
      sel_instr_q  <= 1'b0;
      last_instr_q <= 1'b0;
      cnt_q        <= 4'd0;
    end else begin
      gnt_instr_q <= 1'b0;
      gnt_cache_q <= 1'b0;
      mem_en_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_instr || req_cache) begin
            state_q      <= ISSUE;
            gnt_instr_q  <= win_instr_d;
            gnt_cache_q  <= ~win_instr_d;
            mem_en_q     <= 1'b1;
            mem_addr_q   <= win_instr_d ? addr_instr : addr_cache;
            ph0_q        <= win_instr_d ? PH_INSTR : PH_CACHE;
            sel_instr_q  <= win_instr_d;
            last_instr_q <= win_instr_d;
            cnt_q        <= 4'd0;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (cnt_q == LAT_LAST) begin
            data_q  <= {2'b10, mem_rdata};
            state_q <= PRESENT;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        PRESENT: begin
          if (tmo_hit) begin
            data_q  <= 16'h0000;
            ph0_q   <= PH_NONE;
            state_q <= IDLE;
          end else if (ack_s) begin
            data_q  <= 16'h0000;
            state_q <= SPACER;
          end
        end
        SPACER: begin
          if (tmo_hit || !ack_s) begin
            ph0_q   <= PH_NONE;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_instr = gnt_instr_q;
  assign gnt_cache = gnt_cache_q;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign data_out  = data_q;
  assign PH0       = ph0_q;

endmodule

// File: tb/tb_mem_read_seq.sv
// tb/tb_mem_read_seq.sv - scoreboard bench for mem_read_seq (MEM_LAT=2 and MEM_LAT=15 instances)
module tb_mem_read_seq;
  localparam int LAT   = 2;
  localparam int LAT15 = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_instr, req_cache, ack_instr, ack_cache;
  logic [7:0]  addr_instr, addr_cache;
  logic        gnt_instr, gnt_cache, mem_en, err_timeout;
  logic [7:0]  mem_addr;
  logic [13:0] mem_rdata;
  logic [15:0] data_out;
  logic [1:0]  PH0;

  logic        req15, ack15;
  logic [7:0]  addr15;
  logic        gnt15_i, gnt15_c, en15, err15;
  logic [7:0]  maddr15;
  logic [13:0] rdata15;
  logic [15:0] dout15;
  logic [1:0]  ph15;

  int total = 0;
  int bad   = 0;
  logic [17:0] sb [$];
  logic [13:0] mem_model [0:255];

  mem_read_seq #(.MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_instr(req_instr), .addr_instr(addr_instr),
    .req_cache(req_cache), .addr_cache(addr_cache),
    .gnt_instr(gnt_instr), .gnt_cache(gnt_cache),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .data_out(data_out), .PH0(PH0),
    .ack_instr(ack_instr), .ack_cache(ack_cache),
    .err_timeout(err_timeout)
  );

  mem_read_seq #(.MEM_LAT(LAT15)) u_dut15 (
    .clk(clk), .rst_n(rst_n),
    .req_instr(1'b0), .addr_instr(8'h00),
    .req_cache(req15), .addr_cache(addr15),
    .gnt_instr(gnt15_i), .gnt_cache(gnt15_c),
    .mem_en(en15), .mem_addr(maddr15), .mem_rdata(rdata15),
    .data_out(dout15), .PH0(ph15),
    .ack_instr(1'b0), .ack_cache(ack15),
    .err_timeout(err15)
  );

  // Memory models: payload valid only in the cycle exactly LAT cycles after the strobe
  logic       en_dl [0:LAT-1];
  logic [7:0] ad_dl [0:LAT-1];
  always @(posedge clk) begin
    en_dl[0] <= mem_en;
    ad_dl[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) begin
      en_dl[i] <= en_dl[i-1];
      ad_dl[i] <= ad_dl[i-1];
    end
  end
  assign mem_rdata = en_dl[LAT-1] ? mem_model[ad_dl[LAT-1]] : 14'h2AAA;

  logic       en15_dl [0:LAT15-1];
  logic [7:0] ad15_dl [0:LAT15-1];
  always @(posedge clk) begin
    en15_dl[0] <= en15;
    ad15_dl[0] <= maddr15;
    for (int i = 1; i < LAT15; i++) begin
      en15_dl[i] <= en15_dl[i-1];
      ad15_dl[i] <= ad15_dl[i-1];
    end
  end
  assign rdata15 = en15_dl[LAT15-1] ? mem_model[ad15_dl[LAT15-1]] : 14'h2AAA;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_exp(input bit instr, input logic [7:0] a);
    sb.push_back({(instr ? 2'b10 : 2'b00), 2'b10, mem_model[a]});
  endfunction

  task automatic drive(input bit instr, input logic [7:0] a);
    if (instr) begin req_instr = 1'b1; addr_instr = a; end
    else begin req_cache = 1'b1; addr_cache = a; end
    push_exp(instr, a);
  endtask

  task automatic grab(input bit instr, input logic [7:0] a, input bit hold);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!(gnt_instr || gnt_cache) && n < 30);
    check("gnt_seen", 32'(gnt_instr | gnt_cache), 1);
    check("gnt_side", 32'(gnt_instr), 32'(instr));
    check("gnt_other", 32'(gnt_cache), 32'(!instr));
    check("issue_en", 32'(mem_en), 1);
    check("issue_addr", 32'(mem_addr), 32'(a));
    check("issue_ph0", 32'(PH0), instr ? 32'h2 : 32'h0);
    if (!hold) begin
      if (instr) req_instr = 1'b0; else req_cache = 1'b0;
    end
  endtask

  task automatic serve(input bit instr, input bit noise, input int hold_cyc);
    logic [1:0]  code;
    logic [17:0] exp;
    int n;
    bit ph_ok, busy;
    code = instr ? 2'b10 : 2'b00;
    ph_ok = 1'b1;
    busy = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (gnt_instr || gnt_cache || mem_en) busy = 1'b1;
      if (PH0 !== code) ph_ok = 1'b0;
    end while (data_out[15:14] !== 2'b10 && n < 40);
    check("present_lat", n, LAT + 1);
    check("ph0_stable", 32'(ph_ok), 1);
    if (sb.size() > 0) exp = sb.pop_front(); else exp = '1;
    check("data", 32'(data_out), 32'(exp[15:0]));
    check("ph0_present", 32'(PH0), 32'(exp[17:16]));
    if (noise) begin
      if (instr) ack_cache = 1'b1; else ack_instr = 1'b1;
      repeat (6) @(negedge clk);
      if (instr) ack_cache = 1'b0; else ack_instr = 1'b0;
      repeat (3) @(negedge clk);
      check("foreign_ack_ignored", 32'(data_out), 32'(exp[15:0]));
    end
    if (hold_cyc > 0) begin
      repeat (hold_cyc) @(negedge clk);
      check("hold_data", 32'(data_out), 32'(exp[15:0]));
      check("hold_err", 32'(err_timeout), 0);
    end
    if (instr) ack_instr = 1'b1; else ack_cache = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (gnt_instr || gnt_cache || mem_en) busy = 1'b1;
    end while (data_out !== 16'h0000 && n < 20);
    check("spacer_lat", n, 3);
    check("spacer_ph0", 32'(PH0), 32'(code));
    if (instr) ack_instr = 1'b0; else ack_cache = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (gnt_instr || gnt_cache || mem_en) busy = 1'b1;
    end while (PH0 !== 2'b01 && n < 20);
    check("idle_lat", n, 3);
    check("idle_data", 32'(data_out), 0);
    check("busy_gnt", 32'(busy), 0);
  endtask

  initial begin
    int n;
    bit ph_ok;
    for (int i = 0; i < 256; i++) mem_model[i] = 14'(i * 97 + 3);
    mem_model[8'h3C] = 14'h1234;
    rst_n = 1'b0;
    req_instr = 1'b0; req_cache = 1'b0; ack_instr = 1'b0; ack_cache = 1'b0;
    addr_instr = 8'h00; addr_cache = 8'h00;
    req15 = 1'b0; ack15 = 1'b0; addr15 = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_data", 32'(data_out), 0);
    check("rst_ph0", 32'(PH0), 32'h1);
    check("rst_en", 32'(mem_en), 0);
    check("rst_gnt", 32'({gnt_instr, gnt_cache}), 0);
    check("rst_err", 32'(err_timeout), 0);
    check("rst_ph0_15", 32'(ph15), 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention from reset: instr, cache, instr
    req_instr = 1'b1; addr_instr = 8'h10;
    req_cache = 1'b1; addr_cache = 8'h20;
    push_exp(1'b1, 8'h10); push_exp(1'b0, 8'h20); push_exp(1'b1, 8'h10);
    for (int k = 0; k < 3; k++) begin
      grab(k != 1, (k != 1) ? 8'h10 : 8'h20, 1'b1);
      if (k == 2) begin req_instr = 1'b0; req_cache = 1'b0; end
      serve(k != 1, 1'b0, 0);
    end

    // Single instruction fetch, payload 14'h1234 at 8'h3C
    drive(1'b1, 8'h3C);
    grab(1'b1, 8'h3C, 1'b0);
    serve(1'b1, 1'b0, 0);

    // Request arriving while busy waits for IDLE
    drive(1'b0, 8'h81);
    grab(1'b0, 8'h81, 1'b0);
    drive(1'b1, 8'hA1);
    serve(1'b0, 1'b0, 0);
    grab(1'b1, 8'hA1, 1'b0);
    serve(1'b1, 1'b0, 0);

    // Foreign ack toggling during an instruction transfer
    drive(1'b1, 8'h42);
    grab(1'b1, 8'h42, 1'b0);
    serve(1'b1, 1'b1, 0);

    // Ack withheld for a long time
    drive(1'b0, 8'h07);
    grab(1'b0, 8'h07, 1'b0);
`ifdef MEM_RD_TIMEOUT_EN
    n = 0;
    do begin @(negedge clk); n++; end while (data_out[15:14] !== 2'b10 && n < 40);
    if (sb.size() > 0) void'(sb.pop_front());
    check("tmo_present", 32'(data_out), 32'({2'b10, mem_model[8'h07]}));
    n = 0;
    do begin @(negedge clk); n++; end while (data_out !== 16'h0000 && n < 400);
    check("tmo_cycles", n, 255);
    check("tmo_err", 32'(err_timeout), 1);
    check("tmo_ph0", 32'(PH0), 32'h1);
    drive(1'b1, 8'h3C);
    grab(1'b1, 8'h3C, 1'b0);
    serve(1'b1, 1'b0, 0);
    check("tmo_err_sticky", 32'(err_timeout), 1);
`else
    serve(1'b0, 1'b0, 300);
`endif

    // Reset during PRESENT with the request still held
    drive(1'b1, 8'h55);
    grab(1'b1, 8'h55, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (data_out[15:14] !== 2'b10 && n < 40);
    check("pre_rst_valid", 32'(data_out[15:14]), 32'h2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(data_out), 0);
    check("mid_rst_ph0", 32'(PH0), 32'h1);
    check("mid_rst_en", 32'(mem_en), 0);
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(1'b1, 8'h55);
    grab(1'b1, 8'h55, 1'b0);
    serve(1'b1, 1'b0, 0);

    // MEM_LAT=15 instance, single cache request
    req15 = 1'b1; addr15 = 8'hC3;
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt15_c && n < 30);
    check("l15_gnt", 32'(gnt15_c), 1);
    check("l15_gnt_i", 32'(gnt15_i), 0);
    check("l15_en", 32'(en15), 1);
    check("l15_ph0_issue", 32'(ph15), 0);
    req15 = 1'b0;
    n = 0;
    ph_ok = 1'b1;
    do begin
      @(negedge clk); n++;
      if (ph15 !== 2'b00) ph_ok = 1'b0;
    end while (dout15[15:14] !== 2'b10 && n < 40);
    check("l15_lat", n, LAT15 + 1);
    check("l15_data", 32'(dout15), 32'({2'b10, mem_model[8'hC3]}));
    check("l15_ph0_stable", 32'(ph_ok), 1);
    ack15 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (dout15 !== 16'h0000 && n < 20);
    check("l15_spacer", n, 3);
    ack15 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (ph15 !== 2'b01 && n < 20);
    check("l15_idle", n, 3);
    check("l15_err", 32'(err15), 0);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
